// File: rtl/demux_router.sv
// demux_router: registered 1-to-N demux with valid/ready handshakes, a one-entry holding register per channel,
// and a saturating counter of discarded words.
module demux_router #(
  parameter int WIDTH = 4,
  parameter int CHANNELS = 4,
  parameter int DROP_MODE = 0,
  parameter int COUNT_W = 8,
  localparam int SEL_W = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      Enable,
  input  logic [SEL_W-1:0]          Select,
  input  logic [WIDTH-1:0]          Signal,
  input  logic                      In_valid,
  output logic                      In_ready,
  output logic [CHANNELS*WIDTH-1:0] Out_data,
  output logic [CHANNELS-1:0]       Out_valid,
  input  logic [CHANNELS-1:0]       Out_ready,
  output logic [COUNT_W-1:0]        Drop_count
);
  logic [CHANNELS-1:0][WIDTH-1:0] hold;
  logic [CHANNELS-1:0] dec, load;
  logic sel_ok, tgt_full, accept, drop;
  assign Out_data = hold;
  assign sel_ok = 32'(Select) < CHANNELS;
  assign dec = sel_ok ? CHANNELS'(1) << Select : '0;
  // the target blocks only if it is full and its consumer is not taking the old word this cycle
  assign tgt_full = |(dec & Out_valid & ~Out_ready);
  assign In_ready = rst_n && Enable && (!sel_ok || DROP_MODE != 0 || !tgt_full);
  assign accept = In_valid && In_ready;
  assign load = {CHANNELS{accept}} & dec & (~Out_valid | Out_ready);
  assign drop = accept && (!sel_ok || tgt_full);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      hold <= '0;
      Out_valid <= '0;
      Drop_count <= '0;
    end else begin
      for (int k = 0; k < CHANNELS; k++)
        if (load[k]) begin
          hold[k] <= Signal;
          Out_valid[k] <= 1'b1;
        end else if (Out_valid[k] && Out_ready[k]) begin
          hold[k] <= '0;
          Out_valid[k] <= 1'b0;
        end
      if (drop && Drop_count != '1) Drop_count <= Drop_count + COUNT_W'(1);
    end
endmodule

// File: tb/tb_demux_router.sv
// tb_demux_router: three router configurations share one random stimulus stream; a rule-level model feeds
// scoreboard queues that an independent monitor drains and compares.
module tb_demux_router;
  localparam int N = 3;
  int chs [N] = '{4, 4, 3};
  int dms [N] = '{0, 1, 0};
  logic clk, rst_n, en, iv;
  logic [1:0] sel;
  logic [3:0] sig, ordy;
  logic ir0, ir1, ir2;
  logic [15:0] od0, od1;
  logic [11:0] od2;
  logic [3:0] ov0, ov1;
  logic [2:0] ov2;
  logic [7:0] dc0, dc1, dc2;
  typedef struct packed {
    logic [2:0] ir;
    logic [11:0] ov;
    logic [23:0] cnt;
  } rec_t;
  rec_t cq [$];
  logic [3:0] sb [12][$];
  logic [11:0] occ;
  int cnt [N];
  int vec = 0, mis = 0;

  demux_router #(.WIDTH(4), .CHANNELS(4), .DROP_MODE(0), .COUNT_W(8)) d0 (
    .clk(clk), .rst_n(rst_n), .Enable(en), .Select(sel), .Signal(sig), .In_valid(iv), .In_ready(ir0),
    .Out_data(od0), .Out_valid(ov0), .Out_ready(ordy), .Drop_count(dc0));
  demux_router #(.WIDTH(4), .CHANNELS(4), .DROP_MODE(1), .COUNT_W(8)) d1 (
    .clk(clk), .rst_n(rst_n), .Enable(en), .Select(sel), .Signal(sig), .In_valid(iv), .In_ready(ir1),
    .Out_data(od1), .Out_valid(ov1), .Out_ready(ordy), .Drop_count(dc1));
  demux_router #(.WIDTH(4), .CHANNELS(3), .DROP_MODE(0), .COUNT_W(8)) d2 (
    .clk(clk), .rst_n(rst_n), .Enable(en), .Select(sel), .Signal(sig), .In_valid(iv), .In_ready(ir2),
    .Out_data(od2), .Out_valid(ov2), .Out_ready(ordy[2:0]), .Drop_count(dc2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic dut_ir(int d);
    return d == 0 ? ir0 : d == 1 ? ir1 : ir2;
  endfunction
  function automatic logic [3:0] dut_ov(int d);
    return d == 0 ? ov0 : d == 1 ? ov1 : {1'b0, ov2};
  endfunction
  function automatic logic [7:0] dut_dc(int d);
    return d == 0 ? dc0 : d == 1 ? dc1 : dc2;
  endfunction
  function automatic logic [3:0] dut_lane(int d, int k);
    return d == 0 ? od0[k*4 +: 4] : d == 1 ? od1[k*4 +: 4] : od2[k*4 +: 4];
  endfunction

  task automatic chk(input string n, input int d, input int act, input int exp);
    vec++;
    if (act != exp) begin
      mis++;
      $display("FAIL %s dut%0d got %0d expected %0d at %0t", n, d, act, exp, $time);
    end
  endtask

  // monitor: one expectation record per observed cycle, plus per-channel data queues
  initial forever begin
    rec_t r;
    logic [3:0] v;
    @(negedge clk or negedge rst_n);
    #1;
    if (cq.size() > 0) begin
      r = cq.pop_front();
      for (int d = 0; d < N; d++) begin
        v = dut_ov(d);
        chk("in_ready", d, int'(dut_ir(d)), int'(r.ir[d]));
        chk("out_valid", d, int'(v), int'(r.ov[d*4 +: 4]));
        chk("drop_count", d, int'(dut_dc(d)), int'(r.cnt[d*8 +: 8]));
        for (int k = 0; k < chs[d]; k++)
          if (!v[k]) chk("lane_zero", d, int'(dut_lane(d, k)), 0);
          else if (sb[d*4+k].size() == 0) begin
            vec++;
            mis++;
            $display("FAIL lane_unexpected dut%0d lane %0d got %0d expected no word", d, k, dut_lane(d, k));
          end else begin
            chk("lane_data", d, int'(dut_lane(d, k)), int'(sb[d*4+k][0]));
            if (ordy[k]) void'(sb[d*4+k].pop_front());
          end
      end
    end
  end

  // one cycle of stimulus; the model applies the routing rules and queues what each DUT must show
  task automatic step(input logic e, input logic v, input logic [1:0] s, input logic [3:0] x, input logic [3:0] o);
    rec_t r;
    logic ok, full, er;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    en = e; iv = v; sel = s; sig = x; ordy = o;
    for (int d = 0; d < N; d++) begin
      ok = int'(s) < chs[d];
      full = ok && occ[d*4+s] && !o[s];
      er = e && (!ok || dms[d] == 1 || !full);
      r.ir[d] = er;
      r.ov[d*4 +: 4] = occ[d*4 +: 4];
      r.cnt[d*8 +: 8] = 8'(cnt[d]);
      for (int k = 0; k < chs[d]; k++)
        if (occ[d*4+k] && o[k]) occ[d*4+k] = 1'b0;
      if (v && er && ok && !full) begin
        occ[d*4+s] = 1'b1;
        sb[d*4+s].push_back(x);
      end else if (v && er) cnt[d] = cnt[d] >= 255 ? 255 : cnt[d] + 1;
    end
    cq.push_back(r);
  endtask

  task automatic async_reset();
    rec_t r;
    @(posedge clk);
    #1;
    occ = '0;
    for (int d = 0; d < N; d++) cnt[d] = 0;
    for (int i = 0; i < 12; i++) sb[i].delete();
    r = '0;
    cq.push_back(r);
    #2 rst_n = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; en = 0; iv = 0; sel = 0; sig = 0; ordy = 0;
    occ = '0;
    for (int d = 0; d < N; d++) cnt[d] = 0;
    repeat (3) @(posedge clk);
    step(1, 1, 2, 4'hA, 4'h0);
    step(1, 1, 2, 4'h5, 4'h0);
    step(1, 1, 2, 4'h5, 4'h0);
    step(1, 1, 2, 4'h5, 4'h4);
    step(1, 0, 0, 4'h0, 4'hF);
    for (int i = 0; i < 4; i++) step(1, 1, 2'(i), 4'(i + 1), 4'hF);
    step(1, 0, 0, 4'h0, 4'h0);
    step(1, 1, 1, 4'h7, 4'h0);
    for (int i = 0; i < 3; i++) step(1, 1, 1, 4'(8 + i), 4'h0);
    step(0, 1, 1, 4'h3, 4'h0);
    step(0, 1, 2, 4'h3, 4'hF);
    step(0, 1, 3, 4'h3, 4'h0);
    for (int i = 0; i < 400; i++) begin
      if (i == 200) async_reset();
      step($urandom % 8 != 0, $urandom % 4 != 0, 2'($urandom), 4'($urandom),
           4'($urandom) | ((i % 50 < 25) ? 4'h0 : 4'($urandom)));
    end
    for (int i = 0; i < 300; i++) step(1, 1, 3, 4'($urandom), 4'($urandom));
    async_reset();
    step(1, 1, 0, 4'h9, 4'h0);
    step(1, 0, 0, 4'h0, 4'hF);
    step(1, 0, 0, 4'h0, 4'hF);
    @(negedge clk);
    #3;
    $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
    $finish;
  end
endmodule

// File: doc/demux_router.md
Name: demux_router

Overview:
- Parametrised, registered 1-to-N demultiplexer: the sequential successor of the team's combinational 4-way, 4-bit demux.
- Routes one input word per accepted transfer to the output channel chosen by Select.
- Uses a valid/ready handshake on the input and on every output channel.
- Each channel has a one-entry holding register, so downstream stalls are absorbed per channel. Sits between a single producer (switch/FSM stage) and up to N independent consumers.

Parameters:
- WIDTH, 4: data width of Signal and of each output channel.
- CHANNELS, 4: number of output channels; legal range 2..16; need not be a power of 2.
- DROP_MODE, 0: 0 = back-pressure the input when the target channel is full; 1 = accept and discard, then count.
- COUNT_W, 8: width of the Drop_count saturating counter.
- SEL_W (localparam): $clog2(CHANNELS).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- Enable  input  1  global enable; when low, no input is accepted.
- Select  input  SEL_W  target channel index.
- Signal  input  WIDTH  input data word.
- In_valid  input  1  producer has a word.
- In_ready  output  1  block can take the word this cycle.
- Out_data  output  CHANNELS*WIDTH  flattened channel data; channel k occupies bits [k*WIDTH +: WIDTH].
- Out_valid  output  CHANNELS  per-channel holding register is full.
- Out_ready  input  CHANNELS  per-channel consumer ready.
- Drop_count  output  COUNT_W  saturating count of discarded words.

Behaviour:
- Reset (rst_n low, asynchronous): all Out_valid=0, all holding registers=0, Drop_count=0. In_ready is combinational and is 0 while in reset.
- Transfer rules:
  - Input transfer = In_valid && In_ready at a rising edge.
  - Output transfer on channel k = Out_valid[k] && Out_ready[k].
- In_ready (combinational):
  - 0 when Enable=0.
  - Otherwise 1 when Select >= CHANNELS, or DROP_MODE=1, or !Out_valid[Select], or Out_ready[Select].
  - In_ready never depends on In_valid.
- Accepted word, Select < CHANNELS, channel free or draining this cycle:
  - Write Signal into holding register[Select].
  - Set Out_valid[Select]=1 next cycle. Input-to-output latency is exactly 1 cycle.
- Simultaneous drain and fill on the same channel:
  - The old word leaves and the new word is loaded in the same edge.
  - Out_valid stays 1, giving full throughput of 1 word/cycle per channel.
- Drops:
  - Accepted word with Select >= CHANNELS: discard; Drop_count += 1.
  - DROP_MODE=1, target channel full, and Out_ready[Select]=0: discard the word. The holding register keeps its old word and Drop_count += 1.
  - Drop_count saturates at 2^COUNT_W-1 and never wraps.
- Channel k with Out_valid[k] && !Out_ready[k]: data and valid hold stable until the transfer completes.
- Channel k drains with no new word loaded: Out_valid[k]=0 next cycle, and the holding register clears to 0.
- Out_data lanes of empty channels therefore read 0, preserving the "unselected outputs are zero" behaviour of the earlier demux.
- Channels are independent. A stall on one channel never blocks a different Select target.
- Enable=0:
  - No accepts and no drop-count changes.
  - Already-held words still drain normally.
- Select and Signal are sampled only on an input transfer. Changes in other cycles have no effect.
- Reset mid-operation: held words are lost, valids clear immediately, and the counter clears. No partial transfer survives reset.

Test Plan:
1. Reset, then Enable=1, In_valid=1, Select=2, Signal=4'hA, all Out_ready=0 → In_ready=1. Next cycle Out_valid=4'b0100 and lane 2=4'hA, other lanes 0.
2. Channel 2 full, Out_ready[2]=0, DROP_MODE=0, send Select=2 Signal=4'h5 → In_ready=0 and lane 2 stays 4'hA. Raise Out_ready[2] → In_ready=1; after the edge lane 2=4'h5 and Out_valid[2] stays 1.
3. Back-to-back stream Select=0,1,2,3 with data 1,2,3,4 and all Out_ready=1 → each lane shows its word exactly one cycle after acceptance. In_ready stays 1 throughout.
4. DROP_MODE=1, channel 1 full and stalled, send 3 words to Select=1 → all accepted, lane 1 unchanged, Drop_count=3.
5. CHANNELS=3, Select=3 → accepted, no Out_valid change, Drop_count increments. Drive 300 such words with COUNT_W=8 → Drop_count saturates at 255.
6. Enable=0 with In_valid=1 → In_ready=0, no state change while held words still drain. Assert rst_n=0 mid-stream → Out_valid=0 and Drop_count=0 immediately, without waiting for a clock edge.
